// File: rtl/std_occupancy_tracker.sv
// ---------------------------------------------------------------------------
// std_occupancy_tracker
//
// Purpose: a bank of CHANNELS independent occupancy trackers, one per channel.
// Each channel tracks a circular buffer of DEPTH entries: a write pointer
// (front_value), a read pointer (rear_value) and the occupancy (value). Each
// cycle a channel may push and/or pop a variable number of entries. A request
// that would overrun the capacity or underrun the occupancy is rejected and
// latched in a sticky error flag. All decisions use the occupancy as it was
// at the start of the cycle.
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-high reset (all channels)
//   push_enable     in   [CHANNELS]              push request per channel
//   push_count      in   [CHANNELS][STEP_WIDTH]  entries to push
//   pop_enable      in   [CHANNELS]              pop request per channel
//   pop_count       in   [CHANNELS][STEP_WIDTH]  entries to pop
//   clear           in   [CHANNELS]              synchronous channel reinitialise
//   front_value     out  [CHANNELS][PTR_WIDTH]   write pointer
//   rear_value      out  [CHANNELS][PTR_WIDTH]   read pointer
//   value           out  [CHANNELS][COUNT_WIDTH] occupancy 0..DEPTH
//   empty           out  [CHANNELS]              value == 0
//   full            out  [CHANNELS]              value == DEPTH
//   almost_full     out  [CHANNELS]              value >= ALMOST_FULL
//   overflow_error  out  [CHANNELS]              sticky rejected-push flag
//   underflow_error out  [CHANNELS]              sticky rejected-pop flag
// ---------------------------------------------------------------------------
module std_occupancy_tracker #(
  parameter CLOCK_INFO = 'b0,
  parameter int CHANNELS = 2,
  parameter int DEPTH = 8,
  parameter int STEP_WIDTH = 2,
  parameter int ALMOST_FULL = DEPTH - 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [CHANNELS-1:0]                          push_enable,
  input  logic [CHANNELS-1:0][STEP_WIDTH-1:0]          push_count,
  input  logic [CHANNELS-1:0]                          pop_enable,
  input  logic [CHANNELS-1:0][STEP_WIDTH-1:0]          pop_count,
  input  logic [CHANNELS-1:0]                          clear,
  output logic [CHANNELS-1:0][$clog2(DEPTH)-1:0]       front_value,
  output logic [CHANNELS-1:0][$clog2(DEPTH)-1:0]       rear_value,
  output logic [CHANNELS-1:0][$clog2(DEPTH+1)-1:0]     value,
  output logic [CHANNELS-1:0]                          empty,
  output logic [CHANNELS-1:0]                          full,
  output logic [CHANNELS-1:0]                          almost_full,
  output logic [CHANNELS-1:0]                          overflow_error,
  output logic [CHANNELS-1:0]                          underflow_error
);

  localparam int PTR_WIDTH   = $clog2(DEPTH);
  localparam int COUNT_WIDTH = $clog2(DEPTH+1);
  // Arithmetic width wide enough for both occupancy and step amounts, plus a
  // spare bit so that capacity comparisons never wrap.
  localparam int AW = ((COUNT_WIDTH > STEP_WIDTH) ? COUNT_WIDTH : STEP_WIDTH) + 1;

  // The registers below are implemented inline with rising-edge clocking and
  // asynchronous reset; a non-default clock descriptor selects no alternative
  // register flavour in this build.
  if (CLOCK_INFO != 0) begin : g_clock_info_nondefault
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
    logic [PTR_WIDTH-1:0]   front_reg, front_next;
    logic [PTR_WIDTH-1:0]   rear_reg, rear_next;
    logic [COUNT_WIDTH-1:0] value_reg, value_next;
    logic                   overflow_reg, overflow_next;
    logic                   underflow_reg, underflow_next;

    logic [AW-1:0] push_amt, pop_amt, cur_amt, space_amt;
    logic [AW:0]   front_sum, rear_sum;
    logic          push_ok, pop_ok;

    always_comb begin
      push_amt  = AW'(push_count[gi]);
      pop_amt   = AW'(pop_count[gi]);
      cur_amt   = AW'(value_reg);
      space_amt = AW'(DEPTH) - cur_amt;

      // Acceptance uses only the occupancy at the start of the cycle: a
      // simultaneous pop frees no room for the push and vice versa.
      push_ok = push_enable[gi] && (push_amt <= space_amt);
      pop_ok  = pop_enable[gi] && (pop_amt <= cur_amt);

      // An accepted step never exceeds DEPTH, so the pointer sum is below
      // 2*DEPTH and one conditional subtract gives an exact modulo for any
      // DEPTH, power of two or not.
      front_sum = (AW+1)'(front_reg) + (AW+1)'(push_amt);
      if (front_sum >= (AW+1)'(DEPTH)) begin
        front_sum = front_sum - (AW+1)'(DEPTH);
      end
      rear_sum = (AW+1)'(rear_reg) + (AW+1)'(pop_amt);
      if (rear_sum >= (AW+1)'(DEPTH)) begin
        rear_sum = rear_sum - (AW+1)'(DEPTH);
      end

      front_next     = front_reg;
      rear_next      = rear_reg;
      value_next     = value_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;

      if (clear[gi]) begin
        front_next     = '0;
        rear_next      = '0;
        value_next     = '0;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
      end else begin
        if (push_ok) begin
          front_next = PTR_WIDTH'(front_sum);
        end else if (push_enable[gi]) begin
          overflow_next = 1'b1;
        end
        if (pop_ok) begin
          rear_next = PTR_WIDTH'(rear_sum);
        end else if (pop_enable[gi]) begin
          underflow_next = 1'b1;
        end
        value_next = COUNT_WIDTH'(cur_amt + (push_ok ? push_amt : '0)
                                          - (pop_ok ? pop_amt : '0));
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        front_reg     <= '0;
        rear_reg      <= '0;
        value_reg     <= '0;
        overflow_reg  <= 1'b0;
        underflow_reg <= 1'b0;
      end else begin
        front_reg     <= front_next;
        rear_reg      <= rear_next;
        value_reg     <= value_next;
        overflow_reg  <= overflow_next;
        underflow_reg <= underflow_next;
      end
    end

    assign front_value[gi]     = front_reg;
    assign rear_value[gi]      = rear_reg;
    assign value[gi]           = value_reg;
    assign overflow_error[gi]  = overflow_reg;
    assign underflow_error[gi] = underflow_reg;

    // Status flags decode the registered occupancy directly.
    assign empty[gi]       = (value_reg == '0);
    assign full[gi]        = (value_reg == COUNT_WIDTH'(DEPTH));
    assign almost_full[gi] = (value_reg >= COUNT_WIDTH'(ALMOST_FULL));
  end

endmodule

// File: tb/tb_std_occupancy_tracker.sv
// Directed bench for std_occupancy_tracker with CHANNELS=2, DEPTH=6,
// STEP_WIDTH=3, ALMOST_FULL=4. Expected values are hand-computed constants.
module tb_std_occupancy_tracker;

  localparam int CH = 2;
  localparam int DEPTH = 6;
  localparam int SW = 3;
  localparam int AF = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [CH-1:0]         push_enable = '0;
  logic [CH-1:0][SW-1:0] push_count = '0;
  logic [CH-1:0]         pop_enable = '0;
  logic [CH-1:0][SW-1:0] pop_count = '0;
  logic [CH-1:0]         clear = '0;
  logic [CH-1:0][2:0]    front_value;
  logic [CH-1:0][2:0]    rear_value;
  logic [CH-1:0][2:0]    value;
  logic [CH-1:0]         empty, full, almost_full;
  logic [CH-1:0]         overflow_error, underflow_error;

  int n_cmp = 0;
  int n_bad = 0;

  std_occupancy_tracker #(
    .CLOCK_INFO ('b0),
    .CHANNELS   (CH),
    .DEPTH      (DEPTH),
    .STEP_WIDTH (SW),
    .ALMOST_FULL(AF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .push_enable    (push_enable),
    .push_count     (push_count),
    .pop_enable     (pop_enable),
    .pop_count      (pop_count),
    .clear          (clear),
    .front_value    (front_value),
    .rear_value     (rear_value),
    .value          (value),
    .empty          (empty),
    .full           (full),
    .almost_full    (almost_full),
    .overflow_error (overflow_error),
    .underflow_error(underflow_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compares every output of one channel; flags follow from the expected value.
  task automatic check_ch(input string tag, input int ch, input int v, input int f,
                          input int r, input int of, input int uf);
    check($sformatf("%s ch%0d value", tag, ch), 32'(value[ch]), 32'(v));
    check($sformatf("%s ch%0d front", tag, ch), 32'(front_value[ch]), 32'(f));
    check($sformatf("%s ch%0d rear", tag, ch), 32'(rear_value[ch]), 32'(r));
    check($sformatf("%s ch%0d overflow", tag, ch), 32'(overflow_error[ch]), 32'(of));
    check($sformatf("%s ch%0d underflow", tag, ch), 32'(underflow_error[ch]), 32'(uf));
    check($sformatf("%s ch%0d empty", tag, ch), 32'(empty[ch]), 32'(v == 0));
    check($sformatf("%s ch%0d full", tag, ch), 32'(full[ch]), 32'(v == DEPTH));
    check($sformatf("%s ch%0d almost_full", tag, ch), 32'(almost_full[ch]), 32'(v >= AF));
    $display("[%0t] %s ch%0d: value=%0d front=%0d rear=%0d ovf=%0d udf=%0d", $time, tag, ch,
             value[ch], front_value[ch], rear_value[ch], overflow_error[ch], underflow_error[ch]);
  endtask

  task automatic idle();
    push_enable = '0;
    push_count  = '0;
    pop_enable  = '0;
    pop_count   = '0;
    clear       = '0;
  endtask

  task automatic req(input int ch, input int pe, input int pc, input int oe, input int oc);
    push_enable[ch] = pe[0];
    push_count[ch]  = pc[SW-1:0];
    pop_enable[ch]  = oe[0];
    pop_count[ch]   = oc[SW-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    check_ch("reset", 0, 0, 0, 0, 0, 0);
    check_ch("reset", 1, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk) rst = 1'b0;
    tick();

    // Push 3 then push 2 on ch0.
    idle(); req(0, 1, 3, 0, 0);
    tick();
    check_ch("push3", 0, 3, 3, 0, 0, 0);
    idle(); req(0, 1, 2, 0, 0);
    tick();
    check_ch("push2", 0, 5, 5, 0, 0, 0);
    check_ch("push2", 1, 0, 0, 0, 0, 0);

    // Overflowing push rejected, then exact fill wraps the write pointer.
    idle(); req(0, 1, 2, 0, 0);
    tick();
    check_ch("push2_reject", 0, 5, 5, 0, 1, 0);
    idle(); req(0, 1, 1, 0, 0);
    tick();
    check_ch("push1_wrap", 0, 6, 0, 0, 1, 0);

    // Pop 4 with push 3: no credit for the pop, so the push is rejected.
    idle(); req(0, 1, 3, 1, 4);
    tick();
    check_ch("pop4_push3", 0, 2, 0, 4, 1, 0);

    // Underflowing pop leaves state unchanged.
    idle(); req(0, 0, 0, 1, 3);
    tick();
    check_ch("pop3_reject", 0, 2, 0, 4, 1, 1);

    // Pop 2 + push 4 together on ch0; ch1 gets zero-count requests (no-ops).
    idle(); req(0, 1, 4, 1, 2); req(1, 1, 0, 1, 0);
    tick();
    check_ch("pop2_push4", 0, 4, 4, 0, 1, 1);
    check_ch("zero_counts", 1, 0, 0, 0, 0, 0);

    // Clear dominates a push on ch0; ch1 pushes 5 independently.
    idle(); clear[0] = 1'b1; req(0, 1, 1, 0, 0); req(1, 1, 5, 0, 0);
    tick();
    check_ch("clear", 0, 0, 0, 0, 0, 0);
    check_ch("ch1_push5", 1, 5, 5, 0, 0, 0);

    // ch0 fills from empty in one step; ch1 both requests rejected.
    idle(); req(0, 1, 6, 0, 0); req(1, 1, 2, 1, 7);
    tick();
    check_ch("push6_fill", 0, 6, 0, 0, 0, 0);
    check_ch("ch1_both_reject", 1, 5, 5, 0, 1, 1);

    // Mid-test reset pulse: outputs drop asynchronously, in-flight push discarded.
    idle(); req(0, 1, 2, 0, 0);
    #1 rst = 1'b1;
    #1;
    check_ch("rst_async", 0, 0, 0, 0, 0, 0);
    check_ch("rst_async", 1, 0, 0, 0, 0, 0);
    tick();
    check_ch("rst_held", 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    check_ch("after_rst", 0, 2, 2, 0, 0, 0);
    check_ch("after_rst", 1, 0, 0, 0, 0, 0);

    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/std_occupancy_tracker.md
STD_OCCUPANCY_TRACKER -- requirements
Module: std_occupancy_tracker

Interface
REQ-001 SHALL have parameter CLOCK_INFO, default 'b0, meaning std_clock_info_t passed to every internal std_register.
REQ-002 SHALL have parameter CHANNELS, default 2, meaning the number of independent trackers (1 or more).
REQ-003 SHALL have parameter DEPTH, default 8, meaning the per-channel capacity (2 or more; need not be a power of two).
REQ-004 SHALL have parameter STEP_WIDTH, default 2, meaning the width of the per-cycle push/pop amounts.
REQ-005 SHALL have parameter ALMOST_FULL, default DEPTH-1, meaning the occupancy at or above which almost_full asserts.
REQ-006 SHALL derive PTR_WIDTH = $clog2(DEPTH) and COUNT_WIDTH = $clog2(DEPTH+1) as localparams.
REQ-007 SHALL have one clock; reset is asynchronous and active-high; ports are clk and rst.
REQ-008 clk  input  1  clock; all state updates on the rising edge.
REQ-009 rst  input  1  asynchronous active-high reset.
REQ-010 push_enable  input  [CHANNELS]  per-channel push request.
REQ-011 push_count  input  [CHANNELS][STEP_WIDTH]  number of entries to push.
REQ-012 pop_enable  input  [CHANNELS]  per-channel pop request.
REQ-013 pop_count  input  [CHANNELS][STEP_WIDTH]  number of entries to pop.
REQ-014 clear  input  [CHANNELS]  synchronous per-channel reinitialise.
REQ-015 front_value  output  [CHANNELS][PTR_WIDTH]  write pointer.
REQ-016 rear_value  output  [CHANNELS][PTR_WIDTH]  read pointer.
REQ-017 value  output  [CHANNELS][COUNT_WIDTH]  occupancy, range 0..DEPTH.
REQ-018 empty, full, almost_full  output  [CHANNELS]  status flags.
REQ-019 overflow_error, underflow_error  output  [CHANNELS]  sticky error flags.

Function
REQ-020 Channels SHALL be fully independent; no input of channel i affects state of channel j.
REQ-021 front_value, rear_value, value and the error flags SHALL be registered; a change becomes visible one cycle after the sampling edge.
REQ-022 empty = (value==0), full = (value==DEPTH) and almost_full = (value>=ALMOST_FULL) SHALL be combinational decodes of registered value, with no added latency.
REQ-023 A push SHALL be accepted iff push_enable and push_count <= DEPTH - value (current value; a same-cycle pop earns no credit).
REQ-024 A pop SHALL be accepted iff pop_enable and pop_count <= value (current value; a same-cycle push earns no credit).
REQ-025 Accepted push: front_value' = (front_value + push_count) mod DEPTH; wrap SHALL be exact for non-power-of-two DEPTH.
REQ-026 Accepted pop: rear_value' = (rear_value + pop_count) mod DEPTH.
REQ-027 value' SHALL equal value + accepted push_count - accepted pop_count; simultaneous push and pop SHALL both apply in the same cycle.
REQ-028 A rejected push SHALL leave front_value unchanged and set overflow_error; a rejected pop SHALL leave rear_value unchanged and set underflow_error; the other operation SHALL still proceed.
REQ-029 A count of 0 with its enable asserted SHALL be accepted as a no-op and SHALL not set an error.
REQ-030 Error flags SHALL stay set until clear or rst.
REQ-031 clear SHALL dominate that channel's push and pop: front_value, rear_value and value go to 0 and both errors clear on the next edge.
REQ-032 Invariant: value == (front_value - rear_value) mod DEPTH, except when value is 0 or DEPTH, where front_value == rear_value.

Reset
REQ-033 While rst is high, all channels SHALL asynchronously force front_value=0, rear_value=0, value=0 and both errors to 0, giving empty=1, full=0 and almost_full=0 (ALMOST_FULL>0).
REQ-034 Assertion of rst mid-operation SHALL discard in-flight requests; the first update after deassertion SHALL be from the first rising edge with rst low.

Verification (CHANNELS=2, DEPTH=6, STEP_WIDTH=3, ALMOST_FULL=4)
REQ-035 Reset then push 3 and push 2 on ch0 -> value=5, front=5, rear=0, almost_full=1, ch1 stays value=0 and empty=1.
REQ-036 From value=5, front=5, push 2 -> rejected: value=5, front=5, overflow_error=1; then push 1 -> value=6, full=1, front=0 (wrap).
REQ-037 From value=6, rear=0, pop 4 together with push 3 -> pop accepted, push rejected (no credit): value=2, rear=4, overflow_error=1.
REQ-038 From value=2, rear=4, front=0, pop 3 -> underflow_error=1, state unchanged; then pop 2 + push 4 -> value=4, rear=0, front=4.
REQ-039 clear on ch0 with push 1 asserted -> ch0 front=rear=value=0 and errors=0; ch1 unaffected; rst pulsed mid-test -> all outputs at reset values asynchronously.
